core_controller: RTL and testbench
==================================

# core_controller

Sequencing controller for the fetch unit. Generates `core_control_stall_fetch_unit` and `core_control_halt` from dispatch backpressure, ROB restarts and the committed HALT. Runs the end-of-program dcache flush handshake and raises the core-level halt once memory is clean. Sits in `core`, between ROB/dispatch and `fetch_unit`/dcache.

## Interface
Parameters:
- `RESTART_STALL_CYCLES`, default 2: cycles fetch is held after a ROB restart (legal range 1..15).
- `CNT_WIDTH`, default 4: restart counter width; must satisfy `RESTART_STALL_CYCLES < 2**CNT_WIDTH`.

Ports (one clock `CLK`; reset `nRST` is asynchronous and active-low):
- `CLK`  in  1  clock.
- `nRST`  in  1  async active-low reset.
- `dispatch_full`  in  1  dispatch/IQ/ROB cannot accept an instruction this cycle.
- `rob_restart`  in  1  ROB is redirecting fetch; same cycle as `from_pipeline_take_resolved`.
- `rob_commit_halt`  in  1  HALT retired at ROB head this cycle.
- `dcache_flush_done`  in  1  dcache write-back of all dirty lines complete (level).
- `core_control_stall_fetch_unit`  out  1  freeze fetch PC, suppress ivalid.
- `core_control_halt`  out  1  stop fetch, raise icache halt.
- `dcache_flush_req`  out  1  request dcache flush; held until done.
- `core_halt`  out  1  core finished; sticky until reset.
- `core_state_out`  out  3  current state encoding.
- `stall_cycle_count`  out  32  perf counter (see Configuration).

## Operation
- States: `CC_RUN`=0, `CC_RESTART`=1, `CC_FLUSH`=2, `CC_HALTED`=3.
- `CC_RUN`:
  - `rob_commit_halt` goes to `CC_FLUSH`.
  - Otherwise `rob_restart` goes to `CC_RESTART` and loads `restart_cnt = RESTART_STALL_CYCLES-1`.
  - Otherwise stay in `CC_RUN`.
- `CC_RESTART`:
  - `rob_commit_halt` goes to `CC_FLUSH`.
  - `rob_restart` reloads the counter and stays in `CC_RESTART`.
  - Otherwise, `restart_cnt==0` goes to `CC_RUN`; else decrement.
- `CC_FLUSH`:
  - `dcache_flush_done` goes to `CC_HALTED`.
  - `rob_restart` and `dispatch_full` are ignored.
- `CC_HALTED`: absorbing until `nRST`. All inputs are ignored.
- Simultaneous `rob_commit_halt` and `rob_restart`: halt wins.
- Output equations:
  - `core_control_stall_fetch_unit` = `dispatch_full` when state is `CC_RUN`; otherwise 1 (`CC_RESTART`, `CC_FLUSH`, `CC_HALTED`).
  - `core_control_halt` = 1 in `CC_FLUSH` and `CC_HALTED`.
  - `dcache_flush_req` = 1 in `CC_FLUSH` only.
  - `core_halt` = 1 in `CC_HALTED` only.
- Undefined state encoding: next state `CC_RUN`; all outputs take their reset values.

## Timing
- Reset values: state `CC_RUN`, `restart_cnt`=0, `stall_cycle_count`=0.
- Reset output values: all 1-bit outputs 0, `core_state_out`=0.
- `dispatch_full` to stall: combinational, same cycle (Mealy). Fetch never issues into a full dispatch.
- All other outputs are Moore on the registered state and rise the cycle after the triggering input edge.
- Restart at cycle T: stall=1 for cycles T+1..T+`RESTART_STALL_CYCLES`, then follows `dispatch_full` from T+`RESTART_STALL_CYCLES`+1.
- Halt commit at T: `core_control_halt`/`dcache_flush_req` high from T+1.
- `dcache_flush_done` seen at D: `dcache_flush_req` low and `core_halt` high from D+1.
- `dcache_flush_done` high in the same cycle as entry into `CC_FLUSH` is not sampled. At least one flush-request cycle always occurs.
- Reset asserted mid-flush: immediate return to `CC_RUN`, `dcache_flush_req` drops asynchronously.

## Configuration
- `CORE_CONTROL_PERF_EN` defined:
  - `stall_cycle_count` increments each cycle `core_control_stall_fetch_unit`=1 while state is `CC_RUN` or `CC_RESTART`.
  - Saturates at 32'hFFFFFFFF; reset to 0.
- Not defined: `stall_cycle_count` is tied to 32'h0 and no counter register is built. Port list is unchanged.

## Test plan
- Reset, then idle with `dispatch_full` pulsed at cycle 5 -> stall high only in cycle 5; all other outputs 0; state 0.
- `rob_restart` at T, `RESTART_STALL_CYCLES`=2 -> stall high T+1, T+2; low at T+3 with `dispatch_full`=0. Second restart at T+1 -> stall held through T+3.
- `rob_commit_halt` and `rob_restart` together at T -> state `CC_FLUSH` at T+1, `dcache_flush_req`=1, no restart count.
- Flush: `dcache_flush_done` at T+4 -> `dcache_flush_req` 1 for T+1..T+4, `core_halt`=1 from T+5, sticky through 20 cycles of random inputs.
- `nRST` low during `CC_FLUSH` -> all outputs 0 asynchronously. Post-reset `rob_commit_halt` restarts the sequence.
- Perf: with `CORE_CONTROL_PERF_EN`, 3 `dispatch_full` cycles plus one restart (2 cycles) -> count=5. Stalls in `CC_FLUSH` are not counted. Without the macro, the count stays 0.

Source files
------------

// File: rtl/core_controller.sv
// core_controller
//
// Sequencing controller for the fetch unit. Holds fetch while dispatch is
// full, for a fixed number of cycles after a ROB restart, and for good once
// a HALT commits. After a HALT it runs the dcache flush handshake and raises
// the core-level halt when memory is clean.
//
// Parameters:
//   RESTART_STALL_CYCLES  cycles fetch is held after a ROB restart (1..15)
//   CNT_WIDTH             restart counter width (RESTART_STALL_CYCLES < 2**CNT_WIDTH)
//
// Ports:
//   CLK                            clock
//   nRST                           asynchronous active-low reset
//   dispatch_full                  dispatch/IQ/ROB cannot accept this cycle
//   rob_restart                    ROB redirects fetch
//   rob_commit_halt                HALT retired at ROB head
//   dcache_flush_done              dcache write-back complete (level)
//   core_control_stall_fetch_unit  freeze fetch PC, suppress ivalid
//   core_control_halt              stop fetch, raise icache halt
//   dcache_flush_req               request dcache flush, held until done
//   core_halt                      core finished, sticky until reset
//   core_state_out                 current state encoding
//   stall_cycle_count              stall performance counter
//
// Build option:
//   CORE_CONTROL_PERF_EN  when defined, stall_cycle_count counts fetch stall
//                         cycles in CC_RUN/CC_RESTART (saturating). When not
//                         defined the port is tied to zero.

module core_controller #(
    parameter int RESTART_STALL_CYCLES = 2,
    parameter int CNT_WIDTH            = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dispatch_full,
    input  logic        rob_restart,
    input  logic        rob_commit_halt,
    input  logic        dcache_flush_done,
    output logic        core_control_stall_fetch_unit,
    output logic        core_control_halt,
    output logic        dcache_flush_req,
    output logic        core_halt,
    output logic [2:0]  core_state_out,
    output logic [31:0] stall_cycle_count
);

    typedef enum logic [2:0] {
        CC_RUN     = 3'd0,
        CC_RESTART = 3'd1,
        CC_FLUSH   = 3'd2,
        CC_HALTED  = 3'd3
    } cc_state_t;

    // Counter counts down to zero, so the hold lasts RESTART_STALL_CYCLES cycles.
    localparam logic [CNT_WIDTH-1:0] RESTART_RELOAD = CNT_WIDTH'(RESTART_STALL_CYCLES - 1);

    cc_state_t             state;
    cc_state_t             next_state;
    logic [CNT_WIDTH-1:0]  restart_cnt;
    logic [CNT_WIDTH-1:0]  next_restart_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= CC_RUN;
            restart_cnt <= '0;
        end else begin
            state       <= next_state;
            restart_cnt <= next_restart_cnt;
        end
    end

    // A committed HALT takes priority over a restart in every live state.
    always_comb begin
        next_state                    = state;
        next_restart_cnt              = restart_cnt;
        core_control_stall_fetch_unit = 1'b0;
        core_control_halt             = 1'b0;
        dcache_flush_req              = 1'b0;
        core_halt                     = 1'b0;
        core_state_out                = 3'd0;

        case (state)
            CC_RUN: begin
                core_control_stall_fetch_unit = dispatch_full;
                core_state_out                = CC_RUN;
                if (rob_commit_halt) begin
                    next_state = CC_FLUSH;
                end else if (rob_restart) begin
                    next_state       = CC_RESTART;
                    next_restart_cnt = RESTART_RELOAD;
                end
            end
            CC_RESTART: begin
                core_control_stall_fetch_unit = 1'b1;
                core_state_out                = CC_RESTART;
                if (rob_commit_halt) begin
                    next_state = CC_FLUSH;
                end else if (rob_restart) begin
                    next_restart_cnt = RESTART_RELOAD;
                end else if (restart_cnt == '0) begin
                    next_state = CC_RUN;
                end else begin
                    next_restart_cnt = restart_cnt - CNT_WIDTH'(1);
                end
            end
            CC_FLUSH: begin
                core_control_stall_fetch_unit = 1'b1;
                core_control_halt             = 1'b1;
                dcache_flush_req              = 1'b1;
                core_state_out                = CC_FLUSH;
                if (dcache_flush_done) begin
                    next_state = CC_HALTED;
                end
            end
            CC_HALTED: begin
                core_control_stall_fetch_unit = 1'b1;
                core_control_halt             = 1'b1;
                core_halt                     = 1'b1;
                core_state_out                = CC_HALTED;
            end
            default: begin
                // Unreachable encodings recover to CC_RUN with quiet outputs.
                next_state       = CC_RUN;
                next_restart_cnt = '0;
            end
        endcase
    end

`ifdef CORE_CONTROL_PERF_EN
    logic [31:0] stall_cnt;
    logic        count_en;

    // Only stalls caused by backpressure or restarts are counted; the
    // permanent stall of the flush/halt phase would swamp the figure.
    assign count_en = core_control_stall_fetch_unit &&
                      ((state == CC_RUN) || (state == CC_RESTART));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= 32'h0;
        end else if (count_en && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycle_count = stall_cnt;
`else
    assign stall_cycle_count = 32'h0;
`endif

endmodule

// File: tb/tb_core_controller.sv
// tb_core_controller
//
// Directed bench for core_controller with default parameters. The stimulus
// process drives one input vector per cycle and pushes the hand-computed
// expected outputs for that cycle into a queue; the monitor pops and
// compares at each falling clock edge.

module tb_core_controller;

    logic        CLK;
    logic        nRST;
    logic        dispatch_full;
    logic        rob_restart;
    logic        rob_commit_halt;
    logic        dcache_flush_done;
    logic        core_control_stall_fetch_unit;
    logic        core_control_halt;
    logic        dcache_flush_req;
    logic        core_halt;
    logic [2:0]  core_state_out;
    logic [31:0] stall_cycle_count;

    typedef struct {
        logic [3:0]  outs;
        logic [2:0]  state;
        logic [31:0] cnt;
        string       name;
    } exp_t;

    exp_t expQueue[$];
    int   vectorCount;
    int   failCount;
    bit   stimDone;

    core_controller #(
        .RESTART_STALL_CYCLES(2),
        .CNT_WIDTH(4)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .dispatch_full(dispatch_full),
        .rob_restart(rob_restart),
        .rob_commit_halt(rob_commit_halt),
        .dcache_flush_done(dcache_flush_done),
        .core_control_stall_fetch_unit(core_control_stall_fetch_unit),
        .core_control_halt(core_control_halt),
        .dcache_flush_req(dcache_flush_req),
        .core_halt(core_halt),
        .core_state_out(core_state_out),
        .stall_cycle_count(stall_cycle_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Drive one cycle's inputs just after the rising edge and record the
    // outputs expected while those inputs are applied.
    // outs = {stall, core_control_halt, dcache_flush_req, core_halt}
    task automatic applyStimulus(input logic rst, input logic df, input logic rr,
                                 input logic ch, input logic fd,
                                 input logic [3:0] outs, input logic [2:0] st,
                                 input int unsigned cnt, input string name);
        exp_t e;
        @(posedge CLK);
        #1;
        nRST              = rst;
        dispatch_full     = df;
        rob_restart       = rr;
        rob_commit_halt   = ch;
        dcache_flush_done = fd;
        e.outs  = outs;
        e.state = st;
`ifdef CORE_CONTROL_PERF_EN
        e.cnt   = cnt;
`else
        e.cnt   = 32'h0;
`endif
        e.name  = name;
        expQueue.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [3:0] gotOuts;
        gotOuts = {core_control_stall_fetch_unit, core_control_halt,
                   dcache_flush_req, core_halt};
        vectorCount++;
        if (gotOuts !== e.outs || core_state_out !== e.state || stall_cycle_count !== e.cnt) begin
            failCount++;
            $display("[TB] FAIL %s: got outs=%b state=%0d cnt=%0d, expected outs=%b state=%0d cnt=%0d",
                     e.name, gotOuts, core_state_out, stall_cycle_count, e.outs, e.state, e.cnt);
        end
    endtask

    // Monitor: compare whatever the stimulus has queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (expQueue.size() > 0) begin
                e = expQueue.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        nRST              = 1'b0;
        dispatch_full     = 1'b0;
        rob_restart       = 1'b0;
        rob_commit_halt   = 1'b0;
        dcache_flush_done = 1'b0;
        stimDone          = 1'b0;
        vectorCount       = 0;
        failCount         = 0;

        //              rst df rr ch fd  outs    st  cnt name
        applyStimulus(0, 0, 0, 0, 0, 4'b0000, 0, 0, "reset");
        applyStimulus(0, 0, 0, 0, 0, 4'b0000, 0, 0, "reset_hold");
        applyStimulus(1, 0, 0, 0, 0, 4'b0000, 0, 0, "idle1");
        applyStimulus(1, 0, 0, 0, 0, 4'b0000, 0, 0, "idle2");
        applyStimulus(1, 0, 0, 0, 0, 4'b0000, 0, 0, "idle3");
        applyStimulus(1, 0, 0, 0, 0, 4'b0000, 0, 0, "idle4");
        applyStimulus(1, 1, 0, 0, 0, 4'b1000, 0, 0, "df_pulse_c5");
        applyStimulus(1, 0, 0, 0, 0, 4'b0000, 0, 1, "df_released");
        applyStimulus(1, 1, 0, 0, 0, 4'b1000, 0, 1, "df_2");
        applyStimulus(1, 1, 0, 0, 0, 4'b1000, 0, 2, "df_3");
        applyStimulus(1, 0, 1, 0, 0, 4'b0000, 0, 3, "restart_T");
        applyStimulus(1, 0, 0, 0, 0, 4'b1000, 1, 3, "restart_T+1");
        applyStimulus(1, 0, 0, 0, 0, 4'b1000, 1, 4, "restart_T+2");
        applyStimulus(1, 0, 0, 0, 0, 4'b0000, 0, 5, "restart_T+3_run_cnt5");
        applyStimulus(1, 0, 1, 0, 0, 4'b0000, 0, 5, "restart2_T");
        applyStimulus(1, 0, 1, 0, 0, 4'b1000, 1, 5, "restart2_T+1_reload");
        applyStimulus(1, 0, 0, 0, 0, 4'b1000, 1, 6, "restart2_T+2");
        applyStimulus(1, 0, 0, 0, 0, 4'b1000, 1, 7, "restart2_T+3");
        applyStimulus(1, 1, 0, 0, 0, 4'b1000, 0, 8, "run_df_after_restart");
        applyStimulus(1, 1, 1, 1, 1, 4'b1000, 0, 9, "halt_and_restart_T");
        applyStimulus(1, 1, 1, 0, 0, 4'b1110, 2, 10, "flush_T+1");
        applyStimulus(1, 1, 0, 0, 0, 4'b1110, 2, 10, "flush_T+2_nocount");
        applyStimulus(1, 0, 0, 0, 0, 4'b1110, 2, 10, "flush_T+3");
        applyStimulus(1, 0, 0, 0, 1, 4'b1110, 2, 10, "flush_done_T+4");
        applyStimulus(1, 0, 0, 0, 0, 4'b1101, 3, 10, "halted_T+5");
        for (int i = 0; i < 20; i++) begin
            logic [3:0] r;
            r = 4'($urandom);
            applyStimulus(1, r[0], r[1], r[2], r[3], 4'b1101, 3, 10, $sformatf("halted_sticky%0d", i));
        end
        applyStimulus(0, 0, 0, 0, 0, 4'b0000, 0, 0, "reset_from_halted");
        applyStimulus(1, 0, 0, 1, 0, 4'b0000, 0, 0, "halt2_T");
        applyStimulus(1, 0, 0, 0, 0, 4'b1110, 2, 0, "flush2_T+1");
        applyStimulus(0, 0, 0, 0, 0, 4'b0000, 0, 0, "async_reset_midflush");
        applyStimulus(1, 0, 0, 1, 0, 4'b0000, 0, 0, "halt3_T");
        applyStimulus(1, 0, 0, 0, 1, 4'b1110, 2, 0, "flush3_done");
        applyStimulus(1, 0, 0, 0, 0, 4'b1101, 3, 0, "halted3");

        @(negedge CLK);
        @(negedge CLK);
        stimDone = 1'b1;
        vectorCount++;
        if (expQueue.size() != 0) begin
            failCount++;
            $display("[TB] FAIL monitor_drain: %0d vectors left unchecked, expected 0", expQueue.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end

    // Hard stop in case the stimulus process never completes.
    initial begin
        #100000;
        if (!stimDone) begin
            $display("[TB] FAIL timeout: stimulus incomplete, expected completion");
            $fatal(1, "[TB] timeout");
        end
    end

endmodule
